disparity_search_ctrl: RTL
==========================

Name: disparity_search_ctrl

Overview:
- Sequences one shared SAD datapath to search disparities 0..N-1 for one left-image window at a time.
- Latches a left window, fetches the matching right window for each candidate disparity, and drives both windows to the SAD unit.
- Tracks the minimum SAD and emits the winning disparity on a valid/ready output.
- Sits between the window line-buffer and the disparity-map writer.

Parameters:
- PIX_W, 8, bits per pixel.
- WIN, 3, window edge; the window holds WIN*WIN pixels.
- MAX_DISP, 64, largest supported search range; DISP_W = clog2(MAX_DISP).
- SAD_W, 12, SAD result width; default is PIX_W + clog2(WIN*WIN) rounded up.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_range  in  DISP_W+1  number of disparities to search; sampled on accept.
- s_valid  in  1  left window valid.
- s_ready  out  1  controller can accept a left window.
- s_win_l  in  WIN*WIN*PIX_W  left window; pixel i occupies bits [PIX_W*i +: PIX_W].
- r_req  out  1  right-window fetch request.
- r_disp  out  DISP_W  disparity of the requested right window.
- r_ack  in  1  right window present on r_win this cycle.
- r_win  in  WIN*WIN*PIX_W  fetched right window, same packing as s_win_l.
- sad_a  out  WIN*WIN*PIX_W  left operand to the SAD datapath.
- sad_b  out  WIN*WIN*PIX_W  right operand to the SAD datapath.
- sad_in  in  SAD_W  combinational SAD result of sad_a/sad_b.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_disp  out  DISP_W  winning disparity.
- m_sad  out  SAD_W  winning SAD value.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All registers clear: d, best_d, win_l_reg, win_r_reg, m_disp, m_sad = 0; best_sad = all ones.
  - r_req = 0, m_valid = 0; s_ready = 1 (s_ready = state==IDLE).
  - Reset mid-operation aborts the search; no partial result is emitted.
- IDLE:
  - s_ready = 1.
  - On s_valid: latch s_win_l into win_l_reg; n = cfg_range, with 0 treated as 1 and values above MAX_DISP clamped to MAX_DISP.
  - Set d = 0, best_sad = all ones, best_d = 0; go to FETCH.
- FETCH:
  - r_req = 1, r_disp = d.
  - r_req and r_disp are held stable until r_ack; r_ack may arrive in any cycle, including the first.
  - On r_ack: win_r_reg <= r_win; go to COMPARE.
- COMPARE:
  - r_req = 0; sad_a = win_l_reg, sad_b = win_r_reg, both driven from registers (also held in other states).
  - Sample sad_in. If sad_in < best_sad (strict): best_sad <= sad_in, best_d <= d. Ties keep the lower disparity.
  - If d == n-1: go to DONE, loading m_disp <= final best_d and m_sad <= final best_sad, with this cycle's update included.
  - Otherwise d <= d+1 and go to FETCH.
- DONE:
  - m_valid = 1; m_disp and m_sad are registered and stable while m_valid is high.
  - On m_ready: go to IDLE. s_ready rises the following cycle; there is no same-cycle accept/emit overlap.
- Latency with zero-wait r_ack: accept at edge T0, m_valid high from cycle T0 + 2n + 1. Each extra r_ack wait cycle adds 1.
- An r_ack outside FETCH is ignored. s_valid outside IDLE is not accepted.
- If every SAD equals all ones, best_sad is never updated: result is best_d = 0, m_sad = all ones.

Decomposition:
- Package stereo_pkg holds:
  - PIX_W, WIN, MAX_DISP, DISP_W, SAD_W;
  - the state enum {IDLE, FETCH, COMPARE, DONE};
  - a localparam for the window bus width.
- One sub-module, disp_min_tracker: registered strict-less-than compare-and-hold of (best_sad, best_d), with clear and update inputs.
- The SAD datapath stays external and is connected through sad_a, sad_b and sad_in.

Test Plan:
- Bench conditions: cfg_range = 4, r_ack always high, and a SAD model returning 510, 90, 90, 300 for d = 0..3. The 510 case uses left = {0,10,20,30,0,10,20,30,0} and right = {110,100,90,80,70,60,50,40,30}.
  -> r_disp sequence 0,1,2,3; m_valid at T0+9; m_disp = 1, m_sad = 90 (tie keeps d = 1).
- cfg_range = 0 -> exactly one fetch with r_disp = 0; m_disp = 0; m_valid at T0+3.
- r_ack delayed 3 cycles on d = 1 -> r_req and r_disp = 1 held stable for 4 cycles; m_valid delayed by 3 versus the zero-wait case.
- m_ready held low 5 cycles in DONE -> m_valid, m_disp and m_sad stable; s_ready = 0; a second s_valid is not accepted until one cycle after the m_ready handshake.
- All SADs = 4095 with cfg_range = 64 -> m_disp = 0, m_sad = 4095; r_disp reaches 63 and stops.
- rst_n pulsed low during FETCH with d = 2 -> immediately r_req = 0, m_valid = 0, s_ready = 1; next search starts cleanly from d = 0.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared constants and types for the stereo disparity search block.
// Window pixel i sits at bits [PIX_W*i +: PIX_W] of a window bus.
package stereo_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN       = 3;
    localparam int MAX_DISP  = 64;
    localparam int DISP_W    = $clog2(MAX_DISP);
    localparam int SAD_W     = 12;
    localparam int WIN_PIX   = WIN * WIN;
    localparam int WIN_BUS_W = WIN_PIX * PIX_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        COMPARE,
        DONE
    } state_e;

    // A requested range of 0 still searches one disparity; oversize requests saturate.
    function automatic logic [DISP_W:0] clamp_range(input logic [DISP_W:0] req);
        logic [DISP_W:0] res;
        res = req;
        if (req == '0) begin
            res = (DISP_W+1)'(1);
        end else if (req > (DISP_W+1)'(MAX_DISP)) begin
            res = (DISP_W+1)'(MAX_DISP);
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_min_tracker.sv
// Registered running minimum of SAD values with the disparity that produced it.
// Strict less-than compare, so ties keep the earlier (lower) disparity.
module disp_min_tracker
    import stereo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              update,
    input  logic [SAD_W-1:0]  sad_in,
    input  logic [DISP_W-1:0] d_in,
    output logic [SAD_W-1:0]  best_sad,
    output logic [DISP_W-1:0] best_d,
    output logic [SAD_W-1:0]  best_sad_next,
    output logic [DISP_W-1:0] best_d_next
);

    logic [SAD_W-1:0]  best_sad_q, best_sad_d;
    logic [DISP_W-1:0] best_d_q, best_d_d;

    always_comb begin
        best_sad_d = best_sad_q;
        best_d_d   = best_d_q;
        if (clear) begin
            best_sad_d = '1;
            best_d_d   = '0;
        end else if (update && (sad_in < best_sad_q)) begin
            best_sad_d = sad_in;
            best_d_d   = d_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad_q <= '1;
            best_d_q   <= '0;
        end else begin
            best_sad_q <= best_sad_d;
            best_d_q   <= best_d_d;
        end
    end

    assign best_sad      = best_sad_q;
    assign best_d        = best_d_q;
    assign best_sad_next = best_sad_d;
    assign best_d_next   = best_d_d;

endmodule

// File: rtl/disparity_search_ctrl.sv
// Sequences a shared external SAD unit over disparities 0..n-1 for one left
// window and returns the disparity with the lowest SAD on a valid/ready port.
module disparity_search_ctrl
    import stereo_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DISP_W:0]      cfg_range,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIN_BUS_W-1:0] s_win_l,
    output logic                 r_req,
    output logic [DISP_W-1:0]    r_disp,
    input  logic                 r_ack,
    input  logic [WIN_BUS_W-1:0] r_win,
    output logic [WIN_BUS_W-1:0] sad_a,
    output logic [WIN_BUS_W-1:0] sad_b,
    input  logic [SAD_W-1:0]     sad_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DISP_W-1:0]    m_disp,
    output logic [SAD_W-1:0]     m_sad
);

    localparam logic [DISP_W:0]   N_ONE = (DISP_W+1)'(1);
    localparam logic [DISP_W-1:0] D_ONE = DISP_W'(1);

    state_e                 state_q, state_d;
    logic [DISP_W-1:0]      d_q, d_d;
    logic [DISP_W:0]        n_q, n_d;
    logic [WIN_BUS_W-1:0]   win_l_q, win_l_d;
    logic [WIN_BUS_W-1:0]   win_r_q, win_r_d;
    logic [DISP_W-1:0]      m_disp_q, m_disp_d;
    logic [SAD_W-1:0]       m_sad_q, m_sad_d;

    logic                   trk_clear;
    logic                   trk_update;
    logic [SAD_W-1:0]       best_sad, best_sad_next;
    logic [DISP_W-1:0]      best_d, best_d_next;
    logic                   d_is_last;

    disp_min_tracker u_min_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (trk_clear),
        .update        (trk_update),
        .sad_in        (sad_in),
        .d_in          (d_q),
        .best_sad      (best_sad),
        .best_d        (best_d),
        .best_sad_next (best_sad_next),
        .best_d_next   (best_d_next)
    );

    assign d_is_last = ({1'b0, d_q} == (n_q - N_ONE));

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        n_d        = n_q;
        win_l_d    = win_l_q;
        win_r_d    = win_r_q;
        m_disp_d   = m_disp_q;
        m_sad_d    = m_sad_q;
        trk_clear  = 1'b0;
        trk_update = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    win_l_d   = s_win_l;
                    n_d       = clamp_range(cfg_range);
                    d_d       = '0;
                    trk_clear = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (r_ack) begin
                    win_r_d = r_win;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                trk_update = 1'b1;
                // Result registers take the tracker's next value so the final compare counts.
                if (d_is_last) begin
                    m_disp_d = best_d_next;
                    m_sad_d  = best_sad_next;
                    state_d  = DONE;
                end else begin
                    d_d     = d_q + D_ONE;
                    state_d = FETCH;
                end
            end
            DONE: begin
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            d_q      <= '0;
            n_q      <= '0;
            win_l_q  <= '0;
            win_r_q  <= '0;
            m_disp_q <= '0;
            m_sad_q  <= '0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            n_q      <= n_d;
            win_l_q  <= win_l_d;
            win_r_q  <= win_r_d;
            m_disp_q <= m_disp_d;
            m_sad_q  <= m_sad_d;
        end
    end

    assign s_ready = (state_q == IDLE);
    assign r_req   = (state_q == FETCH);
    assign r_disp  = d_q;
    assign sad_a   = win_l_q;
    assign sad_b   = win_r_q;
    assign m_valid = (state_q == DONE);
    assign m_disp  = m_disp_q;
    assign m_sad   = m_sad_q;

endmodule
